// File: rtl/issue_select.sv
// Issue-queue dequeue controller: tag wakeup write-back, oldest-ready select, registered issue port.
// Optional build macro ISSUE_SELECT_WAKEUP_BYPASS_EN lets a same-cycle wakeup make an entry selectable.
module issue_select #(
    parameter  int N_ENTRIES     = 4,
    parameter  int TAG_WIDTH     = 3,
    parameter  int PAYLOAD_WIDTH = 4,
    parameter  int CNT_WIDTH     = 16,
    localparam int ENTRY_WIDTH   = PAYLOAD_WIDTH + 2*(TAG_WIDTH+1),
    localparam int CTR_WIDTH     = $clog2(N_ENTRIES) + 1,
    localparam int ISSUE_WIDTH   = PAYLOAD_WIDTH + 2*TAG_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst_aL,
    input  logic                                   flush,
    input  logic [CTR_WIDTH-1:0]                   queue_count,
    input  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]  entry_douts,
    input  logic                                   deq_valid,
    input  logic [ENTRY_WIDTH-1:0]                 deq_data,
    output logic                                   deq_ready,
    output logic [N_ENTRIES-1:0]                   deq_sel_onehot,
    output logic [N_ENTRIES-1:0]                   wr_en,
    output logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]  wr_data,
    input  logic                                   wakeup_valid,
    input  logic [TAG_WIDTH-1:0]                   wakeup_tag,
    output logic                                   issue_valid,
    input  logic                                   issue_ready,
    output logic [ISSUE_WIDTH-1:0]                 issue_data,
    output logic [CNT_WIDTH-1:0]                   issue_count
);

    localparam int S1_RDY = TAG_WIDTH + 1;
    localparam int S1_TAG = 2*TAG_WIDTH + 1;
    localparam int S2_TAG = TAG_WIDTH;

    logic [N_ENTRIES-1:0] valid;
    logic [N_ENTRIES-1:0] match1;
    logic [N_ENTRIES-1:0] match2;
    logic [N_ENTRIES-1:0] ready;
    logic                 can_accept;
    logic                 fire;
    logic                 deq_unused_bits;

    always_comb begin
        valid  = '0;
        match1 = '0;
        match2 = '0;
        ready  = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            valid[i]  = CTR_WIDTH'(i) < queue_count;
            match1[i] = wakeup_valid && (entry_douts[i][S1_TAG -: TAG_WIDTH] == wakeup_tag);
            match2[i] = wakeup_valid && (entry_douts[i][S2_TAG -: TAG_WIDTH] == wakeup_tag);
`ifdef ISSUE_SELECT_WAKEUP_BYPASS_EN
            ready[i]  = valid[i] && (entry_douts[i][S1_RDY] || match1[i])
                                 && (entry_douts[i][0] || match2[i]);
`else
            ready[i]  = valid[i] && entry_douts[i][S1_RDY] && entry_douts[i][0];
`endif
        end
    end

    // Lowest index wins; with nothing ready the select parks on entry 0.
    always_comb begin
        logic found;
        found          = 1'b0;
        deq_sel_onehot = '0;
        deq_sel_onehot[0] = 1'b1;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            if (ready[i] && !found) begin
                deq_sel_onehot    = '0;
                deq_sel_onehot[i] = 1'b1;
                found             = 1'b1;
            end
        end
    end

    assign can_accept = !issue_valid || issue_ready;
    assign deq_ready  = (|ready) && can_accept && !flush;
    assign fire       = deq_ready && deq_valid;

    // An entry leaving the queue this cycle must not be written back.
    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            wr_en[i] = valid[i] && !flush
                       && ((match1[i] && !entry_douts[i][S1_RDY]) || (match2[i] && !entry_douts[i][0]))
                       && !(fire && deq_sel_onehot[i]);
            if (wr_en[i]) begin
                wr_data[i] = entry_douts[i];
                if (match1[i]) wr_data[i][S1_RDY] = 1'b1;
                if (match2[i]) wr_data[i][0]      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            issue_valid <= 1'b0;
            issue_data  <= '0;
            issue_count <= '0;
        end else begin
            if (flush) begin
                issue_valid <= 1'b0;
            end else if (fire) begin
                issue_valid <= 1'b1;
                issue_data  <= {deq_data[ENTRY_WIDTH-1 -: PAYLOAD_WIDTH],
                                deq_data[S1_TAG -: TAG_WIDTH],
                                deq_data[S2_TAG -: TAG_WIDTH]};
            end else if (issue_ready) begin
                issue_valid <= 1'b0;
            end
            if (fire) issue_count <= issue_count + CNT_WIDTH'(1);
        end
    end

    assign deq_unused_bits = ^{deq_data[S1_RDY], deq_data[0]};

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select: vector table for the select/wakeup logic plus issue-register sequences.
// Expected values follow the build macro ISSUE_SELECT_WAKEUP_BYPASS_EN when it is defined.
module tb_issue_select;

    logic                  clk = 1'b0;
    logic                  rst_aL = 1'b0;
    logic                  flush = 1'b0;
    logic [2:0]            queue_count = '0;
    logic [3:0][11:0]      entry_douts = '0;
    logic                  deq_valid;
    logic [11:0]           deq_data;
    logic                  deq_ready;
    logic [3:0]            deq_sel_onehot;
    logic [3:0]            wr_en;
    logic [3:0][11:0]      wr_data;
    logic                  wakeup_valid = 1'b0;
    logic [2:0]            wakeup_tag = '0;
    logic                  issue_valid;
    logic                  issue_ready = 1'b0;
    logic [9:0]            issue_data;
    logic [15:0]           issue_count;

    int total = 0;
    int bad   = 0;
    int unsigned exp_cnt = 0;

    always #5 clk = ~clk;

    issue_select #(.N_ENTRIES(4), .TAG_WIDTH(3), .PAYLOAD_WIDTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_aL(rst_aL), .flush(flush), .queue_count(queue_count),
        .entry_douts(entry_douts), .deq_valid(deq_valid), .deq_data(deq_data),
        .deq_ready(deq_ready), .deq_sel_onehot(deq_sel_onehot), .wr_en(wr_en),
        .wr_data(wr_data), .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_data(issue_data),
        .issue_count(issue_count)
    );

    // Queue read port model: presents the entry named by the select.
    assign deq_valid = (queue_count != 3'd0);
    always_comb begin
        deq_data = '0;
        for (int i = 0; i < 4; i++)
            if (deq_sel_onehot[i]) deq_data = entry_douts[i];
    end

    function automatic logic [11:0] mk(input logic [3:0] p, input logic [2:0] t1, input logic r1,
                                       input logic [2:0] t2, input logic r2);
        return {p, t1, r1, t2, r2};
    endfunction

    function automatic logic [11:0] rdy_e(input logic [3:0] p);
        return mk(p, 3'd1, 1'b1, 3'd2, 1'b1);
    endfunction

    function automatic logic [11:0] nr5(input logic [3:0] p);
        return mk(p, 3'd5, 1'b0, 3'd2, 1'b1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]       cnt;
        logic [3:0][11:0] ent;
        logic             wv;
        logic [2:0]       wt;
        logic             fl;
        logic             exp_rdy;
        logic [3:0]       exp_sel;
        logic [3:0]       exp_wr;
        logic [3:0][11:0] exp_wd;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mkv(input logic [2:0] cnt, input logic [11:0] e0, input logic [11:0] e1,
                                 input logic [11:0] e2, input logic [11:0] e3, input logic wv,
                                 input logic [2:0] wt, input logic fl, input logic er,
                                 input logic [3:0] es, input logic [3:0] ew, input logic [3:0][11:0] ed);
        vec_t v;
        v.cnt = cnt; v.ent = {e3, e2, e1, e0}; v.wv = wv; v.wt = wt; v.fl = fl;
        v.exp_rdy = er; v.exp_sel = es; v.exp_wr = ew; v.exp_wd = ed;
        return v;
    endfunction

    initial begin
        vecs[0]  = mkv(3'd3, rdy_e(4'hA), nr5(4'hB), rdy_e(4'hC), 12'h0, 1'b0, 3'd0, 1'b0,
                       1'b1, 4'b0001, 4'b0000, '0);
        vecs[1]  = mkv(3'd2, nr5(4'h3), rdy_e(4'h4), 12'h0, 12'h0, 1'b0, 3'd0, 1'b0,
                       1'b1, 4'b0010, 4'b0000, '0);
`ifdef ISSUE_SELECT_WAKEUP_BYPASS_EN
        vecs[2]  = mkv(3'd1, nr5(4'h6), 12'h0, 12'h0, 12'h0, 1'b1, 3'd5, 1'b0,
                       1'b1, 4'b0001, 4'b0000, '0);
`else
        vecs[2]  = mkv(3'd1, nr5(4'h6), 12'h0, 12'h0, 12'h0, 1'b1, 3'd5, 1'b0,
                       1'b0, 4'b0001, 4'b0001, {36'h0, mk(4'h6, 3'd5, 1'b1, 3'd2, 1'b1)});
`endif
        vecs[3]  = mkv(3'd0, nr5(4'h1), 12'h0, 12'h0, 12'h0, 1'b1, 3'd5, 1'b0,
                       1'b0, 4'b0001, 4'b0000, '0);
        vecs[4]  = mkv(3'd4, nr5(4'h1), nr5(4'h2), nr5(4'h3), rdy_e(4'h4), 1'b0, 3'd0, 1'b0,
                       1'b1, 4'b1000, 4'b0000, '0);
        vecs[5]  = mkv(3'd2, rdy_e(4'h7), mk(4'h8, 3'd1, 1'b1, 3'd6, 1'b0), 12'h0, 12'h0, 1'b1, 3'd6, 1'b0,
                       1'b1, 4'b0001, 4'b0010, {24'h0, mk(4'h8, 3'd1, 1'b1, 3'd6, 1'b1), 12'h0});
        vecs[6]  = mkv(3'd1, rdy_e(4'h9), nr5(4'hD), 12'h0, 12'h0, 1'b1, 3'd5, 1'b0,
                       1'b1, 4'b0001, 4'b0000, '0);
        vecs[7]  = mkv(3'd2, rdy_e(4'h9), nr5(4'hD), 12'h0, 12'h0, 1'b1, 3'd5, 1'b1,
                       1'b0, 4'b0001, 4'b0000, '0);
        vecs[8]  = mkv(3'd1, rdy_e(4'hE), 12'h0, 12'h0, 12'h0, 1'b1, 3'd1, 1'b0,
                       1'b1, 4'b0001, 4'b0000, '0);
        vecs[9]  = mkv(3'd1, mk(4'h2, 3'd5, 1'b0, 3'd6, 1'b0), 12'h0, 12'h0, 12'h0, 1'b1, 3'd5, 1'b0,
                       1'b0, 4'b0001, 4'b0001, {36'h0, mk(4'h2, 3'd5, 1'b1, 3'd6, 1'b0)});
        vecs[10] = mkv(3'd4, rdy_e(4'h1), rdy_e(4'h2), rdy_e(4'h3), rdy_e(4'h4), 1'b0, 3'd0, 1'b0,
                       1'b1, 4'b0001, 4'b0000, '0);

        #12 rst_aL = 1'b1;
        step();
        chk("reset_valid", 64'(issue_valid), 64'd0);
        chk("reset_data",  64'(issue_data),  64'd0);
        chk("reset_count", 64'(issue_count), 64'd0);

        // Oldest-ready select
        queue_count = 3'd3; entry_douts = {12'h0, rdy_e(4'hA), nr5(4'hB), rdy_e(4'hC)};
        entry_douts[0] = rdy_e(4'hA); entry_douts[1] = nr5(4'hB); entry_douts[2] = rdy_e(4'hC);
        issue_ready = 1'b1;
        #1;
        chk("oldest_sel", 64'(deq_sel_onehot), 64'b0001);
        chk("oldest_rdy", 64'(deq_ready), 64'd1);
        step(); exp_cnt++;
        chk("oldest_iv",   64'(issue_valid), 64'd1);
        chk("oldest_data", 64'(issue_data),  64'({4'hA, 3'd1, 3'd2}));
        chk("oldest_cnt",  64'(issue_count), 64'(exp_cnt));

        // Backpressure: register holds, then refills on the edge issue_ready returns
        queue_count = 3'd2; entry_douts = '0;
        entry_douts[0] = rdy_e(4'h7); entry_douts[1] = rdy_e(4'h8);
        step(); exp_cnt++;
        chk("bp_load", 64'(issue_data), 64'({4'h7, 3'd1, 3'd2}));
        queue_count = 3'd1; entry_douts = '0; entry_douts[0] = rdy_e(4'h8);
        issue_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_deq_ready", 64'(deq_ready), 64'd0);
            step();
            chk("bp_iv",   64'(issue_valid), 64'd1);
            chk("bp_hold", 64'(issue_data), 64'({4'h7, 3'd1, 3'd2}));
        end
        issue_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 64'(deq_ready), 64'd1);
        step(); exp_cnt++;
        chk("bp_refill", 64'(issue_data), 64'({4'h8, 3'd1, 3'd2}));
        chk("bp_cnt",    64'(issue_count), 64'(exp_cnt));

        // Wakeup of entry 0 src1 via tag 5
        entry_douts = '0; entry_douts[0] = nr5(4'h9);
        wakeup_valid = 1'b1; wakeup_tag = 3'd5;
        #1;
`ifdef ISSUE_SELECT_WAKEUP_BYPASS_EN
        chk("wk_rdy", 64'(deq_ready), 64'd1);
        chk("wk_wr",  64'(wr_en), 64'b0000);
        step(); exp_cnt++;
        wakeup_valid = 1'b0;
`else
        chk("wk_rdy", 64'(deq_ready), 64'd0);
        chk("wk_wr",  64'(wr_en), 64'b0001);
        chk("wk_wd",  64'(wr_data[0]), 64'(mk(4'h9, 3'd5, 1'b1, 3'd2, 1'b1)));
        step();
        chk("wk_nofire_cnt", 64'(issue_count), 64'(exp_cnt));
        entry_douts[0] = mk(4'h9, 3'd5, 1'b1, 3'd2, 1'b1);
        wakeup_valid = 1'b0;
        #1;
        chk("wk_next_rdy", 64'(deq_ready), 64'd1);
        step(); exp_cnt++;
`endif
        chk("wk_iv",   64'(issue_valid), 64'd1);
        chk("wk_data", 64'(issue_data), 64'({4'h9, 3'd5, 3'd2}));
        chk("wk_cnt",  64'(issue_count), 64'(exp_cnt));

        // Flush beats fire and hold
        queue_count = 3'd2; entry_douts = '0;
        entry_douts[0] = rdy_e(4'h5); entry_douts[1] = nr5(4'h6);
        wakeup_valid = 1'b1; wakeup_tag = 3'd5; flush = 1'b1; issue_ready = 1'b0;
        #1;
        chk("fl_rdy", 64'(deq_ready), 64'd0);
        chk("fl_wr",  64'(wr_en), 64'b0000);
        step();
        chk("fl_iv",  64'(issue_valid), 64'd0);
        chk("fl_cnt", 64'(issue_count), 64'(exp_cnt));
        flush = 1'b0; wakeup_valid = 1'b0; issue_ready = 1'b1;

        // Vector table, issue_ready held so the issue port always accepts
        for (int v = 0; v < 11; v++) begin
            queue_count = vecs[v].cnt; entry_douts = vecs[v].ent;
            wakeup_valid = vecs[v].wv; wakeup_tag = vecs[v].wt; flush = vecs[v].fl;
            #1;
            chk($sformatf("v%0d_deq_ready", v), 64'(deq_ready), 64'(vecs[v].exp_rdy));
            chk($sformatf("v%0d_sel", v),       64'(deq_sel_onehot), 64'(vecs[v].exp_sel));
            chk($sformatf("v%0d_wr_en", v),     64'(wr_en), 64'(vecs[v].exp_wr));
            chk($sformatf("v%0d_wr_data", v),   64'(wr_data), 64'(vecs[v].exp_wd));
            if (vecs[v].exp_rdy) exp_cnt++;
            step();
        end
        chk("table_cnt", 64'(issue_count), 64'(exp_cnt));
        flush = 1'b0; wakeup_valid = 1'b0;

        // Asynchronous reset in mid-cycle
        queue_count = 3'd1; entry_douts = '0; entry_douts[0] = rdy_e(4'h6);
        step();
        chk("pre_rst_iv", 64'(issue_valid), 64'd1);
        queue_count = 3'd0;
        #3 rst_aL = 1'b0;
        #1;
        chk("arst_iv",   64'(issue_valid), 64'd0);
        chk("arst_data", 64'(issue_data),  64'd0);
        chk("arst_cnt",  64'(issue_count), 64'd0);
        #2 rst_aL = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
